// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause/mip),
// external-request synchroniser, registered interrupt request and trap entry/return sequencing.
module irq_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        timer_irq,
  input  logic        ext_irq,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        csr_we,
  output logic [31:0] csr_rdata,
  output logic        irq_req,
  input  logic        take,
  input  logic [31:0] take_pc,
  input  logic        mret,
  output logic [31:0] trap_pc,
  output logic [31:0] epc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MIP      = 12'h344;

  // Fixed priority MEI > MSI > MTI; MTI is also the fallback code
  function automatic logic [31:0] irq_cause(input logic [31:0] pend);
    logic [31:0] cause;
    if (pend[11]) begin
      cause = 32'h8000_000B;
    end else if (pend[3]) begin
      cause = 32'h8000_0003;
    end else begin
      cause = 32'h8000_0007;
    end
    return cause;
  endfunction

  logic        ext_s1_q, ext_s2_q;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [2:0]  mie_en_q, mie_en_d;
  logic        msip_q, msip_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mcause_q, mcause_d;
  logic        irq_req_q, irq_req_d;

  logic [31:0] mip_s, mie_s, pend_s;
  logic        take_ok_s;
  logic        wr_mstatus_s, wr_mie_s, wr_mtvec_s, wr_mscratch_s;
  logic        wr_mepc_s, wr_mcause_s, wr_mip_s;
  logic        unused_s;

  assign mip_s     = {20'd0, ext_s2_q, 3'd0, timer_irq, 3'd0, msip_q, 3'd0};
  assign mie_s     = {20'd0, mie_en_q[2], 3'd0, mie_en_q[1], 3'd0, mie_en_q[0], 3'd0};
  assign pend_s    = mip_s & mie_s;
  assign take_ok_s = take & irq_req_q;

  assign wr_mstatus_s  = csr_we & (csr_addr == ADDR_MSTATUS);
  assign wr_mie_s      = csr_we & (csr_addr == ADDR_MIE);
  assign wr_mtvec_s    = csr_we & (csr_addr == ADDR_MTVEC);
  assign wr_mscratch_s = csr_we & (csr_addr == ADDR_MSCRATCH);
  assign wr_mepc_s     = csr_we & (csr_addr == ADDR_MEPC);
  assign wr_mcause_s   = csr_we & (csr_addr == ADDR_MCAUSE);
  assign wr_mip_s      = csr_we & (csr_addr == ADDR_MIP);

  assign irq_req  = irq_req_q;
  assign trap_pc  = {mtvec_q, 2'b00};
  assign epc      = {mepc_q, 2'b00};
  assign unused_s = ^take_pc[1:0];

  // CSR read mux
  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      ADDR_MIE:      csr_rdata = mie_s;
      ADDR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = {mepc_q, 2'b00};
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MIP:      csr_rdata = mip_s;
      default:       csr_rdata = 32'd0;
    endcase
  end

  // Next state: an honoured take beats mret, which beats a software write to mstatus
  always_comb begin
    irq_req_d = mstatus_mie_q & (|pend_s);

    if (take_ok_s) begin
      mstatus_mie_d  = 1'b0;
      mstatus_mpie_d = mstatus_mie_q;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (wr_mstatus_s) begin
      mstatus_mie_d  = csr_wdata[3];
      mstatus_mpie_d = csr_wdata[7];
    end else begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
    end

    if (take_ok_s) begin
      mepc_d   = take_pc[31:2];
      mcause_d = irq_cause(pend_s);
    end else begin
      mepc_d   = wr_mepc_s   ? csr_wdata[31:2] : mepc_q;
      mcause_d = wr_mcause_s ? csr_wdata       : mcause_q;
    end

    if (wr_mie_s) begin
      mie_en_d = {csr_wdata[11], csr_wdata[7], csr_wdata[3]};
    end else begin
      mie_en_d = mie_en_q;
    end

    if (wr_mip_s) begin
      msip_d = csr_wdata[3];
    end else begin
      msip_d = msip_q;
    end

    if (wr_mtvec_s) begin
      mtvec_d = csr_wdata[31:2];
    end else begin
      mtvec_d = mtvec_q;
    end

    if (wr_mscratch_s) begin
      mscratch_d = csr_wdata;
    end else begin
      mscratch_d = mscratch_q;
    end
  end

  // State registers with synchronous active-low reset; reset overrides every request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ext_s1_q       <= 1'b0;
      ext_s2_q       <= 1'b0;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_en_q       <= 3'd0;
      msip_q         <= 1'b0;
      mtvec_q        <= MTVEC_RESET[31:2];
      mepc_q         <= 30'd0;
      mscratch_q     <= 32'd0;
      mcause_q       <= 32'd0;
      irq_req_q      <= 1'b0;
    end else begin
      ext_s1_q       <= ext_irq;
      ext_s2_q       <= ext_s1_q;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_en_q       <= mie_en_d;
      msip_q         <= msip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mscratch_q     <= mscratch_d;
      mcause_q       <= mcause_d;
      irq_req_q      <= irq_req_d;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a word-level CSR model.
module tb_irq_ctrl;

  localparam logic [31:0] MTV_RST = 32'h0000_1003;

  logic        clk;
  logic        resetn;
  logic        timer_irq;
  logic        ext_irq;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic [31:0] csr_rdata;
  logic        irq_req;
  logic        take;
  logic [31:0] take_pc;
  logic        mret;
  logic [31:0] trap_pc;
  logic [31:0] epc;

  irq_ctrl #(.MTVEC_RESET(MTV_RST)) dut (
    .clk(clk), .resetn(resetn), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_rdata(csr_rdata),
    .irq_req(irq_req), .take(take), .take_pc(take_pc), .mret(mret),
    .trap_pc(trap_pc), .epc(epc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (whole-word CSR values) ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic        m_msip, m_irq;
  logic [1:0]  m_sync;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (m_sync[1] ? 32'h800 : 32'h0) | (timer_irq ? 32'h80 : 32'h0)
                    | (m_msip ? 32'h8 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] pend, ms;
    logic        hon, nirq;
    if (!resetn) begin
      m_mstatus = 32'h0; m_mie = 32'h0; m_msip = 1'b0;
      m_mtvec = MTV_RST & 32'hFFFF_FFFC;
      m_mepc = 32'h0; m_mcause = 32'h0; m_mscratch = 32'h0;
      m_sync = 2'b00; m_irq = 1'b0;
      model_valid = 1'b1;
    end else begin
      pend = m_read(12'h344) & m_mie;
      nirq = m_mstatus[3] && (pend != 32'h0);
      hon  = take && m_irq;
      ms   = m_mstatus;
      if (csr_we) begin
        case (csr_addr)
          12'h300: ms = csr_wdata & 32'h88;
          12'h304: m_mie = csr_wdata & 32'h888;
          12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
          12'h340: m_mscratch = csr_wdata;
          12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
          12'h342: m_mcause = csr_wdata;
          12'h344: m_msip = csr_wdata[3];
          default: ;
        endcase
      end
      if (mret && !hon) ms = (m_mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
      if (hon) begin
        ms = m_mstatus[3] ? 32'h80 : 32'h0;
        m_mepc = take_pc & 32'hFFFF_FFFC;
        if (pend[11])     m_mcause = 32'h8000_000B;
        else if (pend[3]) m_mcause = 32'h8000_0003;
        else              m_mcause = 32'h8000_0007;
      end
      m_mstatus = ms;
      m_sync = {m_sync[0], ext_irq};
      m_irq = nirq;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, just after the falling edge
  initial forever begin
    @(negedge clk);
    #1;
    if (model_valid) begin
      chk($sformatf("rdata[%h]", csr_addr), csr_rdata, m_read(csr_addr));
      chk("irq_req", {31'd0, irq_req}, {31'd0, m_irq});
      chk("trap_pc", trap_pc, m_mtvec);
      chk("epc", epc, m_mepc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
    csr_addr = a;
    #1;
    chk(name, csr_rdata, exp);
  endtask

  logic [11:0] addrs [8] = '{12'h300, 12'h304, 12'h305, 12'h340,
                             12'h341, 12'h342, 12'h344, 12'h7C0};

  initial begin
    resetn = 1'b0; timer_irq = 1'b0; ext_irq = 1'b0; csr_addr = 12'h0;
    csr_wdata = 32'h0; csr_we = 1'b0; take = 1'b0; take_pc = 32'h0; mret = 1'b0;
    step(); step();
    resetn = 1'b1;
    rd(12'h300, 32'h0, "rst_mstatus");
    rd(12'h305, 32'h0000_1000, "rst_mtvec");
    rd(12'h304, 32'h0, "rst_mie");
    chk("rst_irq", {31'd0, irq_req}, 32'd0);

    // Timer path
    csr_wr(12'h305, 32'h100);
    csr_wr(12'h304, 32'h80);
    timer_irq = 1'b1;
    csr_wr(12'h300, 32'h8);
    chk("tmr_irq_before", {31'd0, irq_req}, 32'd0);
    step();
    chk("tmr_irq", {31'd0, irq_req}, 32'd1);
    take = 1'b1; take_pc = 32'h2004;
    step();
    take = 1'b0;
    rd(12'h341, 32'h2004, "tmr_mepc");
    rd(12'h342, 32'h8000_0007, "tmr_mcause");
    rd(12'h300, 32'h80, "tmr_mstatus");
    chk("tmr_trap_pc", trap_pc, 32'h100);
    step();
    chk("tmr_irq_drop", {31'd0, irq_req}, 32'd0);

    // mret restore
    timer_irq = 1'b0; mret = 1'b1;
    step();
    mret = 1'b0;
    rd(12'h300, 32'h88, "mret_mstatus");
    chk("mret_epc", epc, 32'h2004);

    // Masking / WARL
    csr_wr(12'h304, 32'h0);
    timer_irq = 1'b1;
    step();
    rd(12'h344, 32'h80, "mask_mip");
    step();
    chk("mask_irq", {31'd0, irq_req}, 32'd0);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h88, "warl_mstatus");
    csr_wr(12'h305, 32'h103);
    rd(12'h305, 32'h100, "warl_mtvec");
    csr_wr(12'h7C0, 32'hFFFF_FFFF);
    rd(12'h7C0, 32'h0, "unmapped");

    // Priority
    csr_wr(12'h344, 32'h8);
    ext_irq = 1'b1;
    csr_wr(12'h304, 32'h888);
    step();
    rd(12'h344, 32'h888, "prio_mip");
    chk("prio_irq", {31'd0, irq_req}, 32'd1);
    take = 1'b1;
    step();
    take = 1'b0;
    rd(12'h342, 32'h8000_000B, "prio_mei");
    ext_irq = 1'b0;
    step(); step();
    rd(12'h344, 32'h88, "prio_mip2");
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
    take = 1'b1;
    step();
    take = 1'b0;
    rd(12'h342, 32'h8000_0003, "prio_msi");

    // Collisions
    mret = 1'b1; step(); mret = 1'b0; step();
    take = 1'b1; mret = 1'b1;
    step();
    take = 1'b0; mret = 1'b0;
    rd(12'h300, 32'h80, "col_take_mret");
    mret = 1'b1; step(); mret = 1'b0; step();
    take = 1'b1; csr_we = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h55;
    step();
    take = 1'b0; csr_we = 1'b0;
    rd(12'h342, 32'h8000_0003, "col_mcause");
    mret = 1'b1; step(); mret = 1'b0; step();
    take = 1'b1; csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
    step();
    take = 1'b0; csr_we = 1'b0;
    rd(12'h340, 32'hDEAD, "col_mscratch");
    rd(12'h300, 32'h80, "col_mstatus");
    csr_we = 1'b1; mret = 1'b1; csr_addr = 12'h300; csr_wdata = 32'h0;
    step();
    csr_we = 1'b0; mret = 1'b0;
    rd(12'h300, 32'h88, "col_mret_wr");

    // Reset mid-request
    step();
    chk("rst_pre_irq", {31'd0, irq_req}, 32'd1);
    resetn = 1'b0; take = 1'b1; csr_we = 1'b1; csr_addr = 12'h340; csr_wdata = 32'h1234;
    step();
    resetn = 1'b1; take = 1'b0; csr_we = 1'b0;
    chk("rst_irq_drop", {31'd0, irq_req}, 32'd0);
    rd(12'h300, 32'h0, "rst2_mstatus");
    rd(12'h304, 32'h0, "rst2_mie");
    rd(12'h305, 32'h1000, "rst2_mtvec");
    rd(12'h340, 32'h0, "rst2_mscratch");
    rd(12'h344, 32'h80, "rst2_mip");

    // take without irq_req, then synchroniser latency
    take = 1'b1; take_pc = 32'h4444;
    step();
    take = 1'b0;
    rd(12'h342, 32'h0, "take_noirq");
    ext_irq = 1'b1;
    step();
    rd(12'h344, 32'h80, "sync_1edge");
    step();
    rd(12'h344, 32'h880, "sync_2edge");
    ext_irq = 1'b0;

    // Randomized traffic, checked each cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      resetn    = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      csr_we    = ($urandom_range(0, 3) == 0);
      csr_addr  = addrs[$urandom_range(0, 7)];
      csr_wdata = $urandom;
      take      = ($urandom_range(0, 2) == 0);
      take_pc   = $urandom;
      mret      = ($urandom_range(0, 5) == 0);
      step();
    end
    resetn = 1'b1; csr_we = 1'b0; take = 1'b0; mret = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
